// File: rtl/receiver_control.sv
// Receive-buffer controller: queues deserialized words into an external
// synchronous RAM used as a 2^AW-deep circular buffer and returns them in order on read.
module receiver_control #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] rdrDataOut,
  input  logic             Received,
  input  logic             read,
  output logic [WIDTH-1:0] rdData,
  output logic             rdValid,
  output logic [WIDTH-1:0] memDataIn,
  input  logic [WIDTH-1:0] memDataOut,
  output logic [AW-1:0]    Address,
  output logic             WriteEnable,
  output logic [AW:0]      Count,
  output logic             Empty,
  output logic             Full,
  output logic             Overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_AFTER_WRITE, S_READ, S_AFTER_READ
  } state_t;

  localparam logic [AW:0]   C_ONE  = 1;
  localparam logic [AW:0]   C_FULL = 1 << AW;
  localparam logic [AW-1:0] P_ONE  = 1;

  state_t           r_state, w_state_nxt;
  logic [AW-1:0]    r_wr_ptr, w_wr_ptr_nxt;
  logic [AW-1:0]    r_rd_ptr, w_rd_ptr_nxt;
  logic [AW:0]      r_count, w_count_nxt;
  logic             r_rx_pend, w_rx_pend_nxt;
  logic [WIDTH-1:0] r_rx_word, w_rx_word_nxt;
  logic             r_rd_pend, w_rd_pend_nxt;
  logic             r_overrun, w_overrun_nxt;
  logic [WIDTH-1:0] r_rd_data, w_rd_data_nxt;
  logic             r_rd_valid, w_rd_valid_nxt;
  logic [WIDTH-1:0] r_mem_din, w_mem_din_nxt;
  logic [AW-1:0]    r_addr, w_addr_nxt;
  logic             r_we, w_we_nxt;
  logic             w_wr_busy, w_rd_busy;
  logic [AW:0]      w_fill;

  // A write already in flight has not reached Count yet; reserve its slot.
  assign w_wr_busy = (r_state == S_WRITE) || (r_state == S_AFTER_WRITE);
  assign w_rd_busy = (r_state == S_READ)  || (r_state == S_AFTER_READ);
  assign w_fill    = r_count + (w_wr_busy ? C_ONE : '0);

  always_comb begin
    w_state_nxt    = r_state;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_count_nxt    = r_count;
    w_rx_pend_nxt  = r_rx_pend;
    w_rx_word_nxt  = r_rx_word;
    w_rd_pend_nxt  = r_rd_pend;
    w_overrun_nxt  = r_overrun;
    w_rd_data_nxt  = r_rd_data;
    w_rd_valid_nxt = 1'b0;
    w_mem_din_nxt  = r_mem_din;
    w_addr_nxt     = r_addr;
    w_we_nxt       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_rx_pend) begin
          w_state_nxt   = S_WRITE;
          w_addr_nxt    = r_wr_ptr;
          w_mem_din_nxt = r_rx_word;
          w_we_nxt      = 1'b1;
          w_rx_pend_nxt = 1'b0;
        end else if (r_rd_pend) begin
          w_rd_pend_nxt = 1'b0;
          if (r_count != '0) begin
            w_state_nxt = S_READ;
            w_addr_nxt  = r_rd_ptr;
          end
        end
      end
      S_WRITE:       w_state_nxt = S_AFTER_WRITE;
      S_AFTER_WRITE: begin
        w_state_nxt  = S_IDLE;
        w_wr_ptr_nxt = r_wr_ptr + P_ONE;
        w_count_nxt  = r_count + C_ONE;
      end
      S_READ:        w_state_nxt = S_AFTER_READ;
      S_AFTER_READ: begin
        w_state_nxt    = S_IDLE;
        w_rd_data_nxt  = memDataOut;
        w_rd_valid_nxt = 1'b1;
        w_rd_ptr_nxt   = r_rd_ptr + P_ONE;
        w_count_nxt    = r_count - C_ONE;
      end
      default:       w_state_nxt = S_IDLE;
    endcase

    // Input capture comes last; it only fires when the pending flag is clear,
    // so it never collides with the FSM consuming that flag.
    if (Received) begin
      if (!r_rx_pend && (w_fill < C_FULL)) begin
        w_rx_pend_nxt = 1'b1;
        w_rx_word_nxt = rdrDataOut;
      end else begin
        w_overrun_nxt = 1'b1;
      end
    end
    if (read && !r_rd_pend && !w_rd_busy)
      w_rd_pend_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rx_pend  <= 1'b0;
      r_rx_word  <= '0;
      r_rd_pend  <= 1'b0;
      r_overrun  <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_mem_din  <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_rx_pend  <= w_rx_pend_nxt;
      r_rx_word  <= w_rx_word_nxt;
      r_rd_pend  <= w_rd_pend_nxt;
      r_overrun  <= w_overrun_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_mem_din  <= w_mem_din_nxt;
      r_addr     <= w_addr_nxt;
      r_we       <= w_we_nxt;
    end
  end

  assign rdData      = r_rd_data;
  assign rdValid     = r_rd_valid;
  assign memDataIn   = r_mem_din;
  assign Address     = r_addr;
  assign WriteEnable = r_we;
  assign Count       = r_count;
  assign Empty       = (r_count == '0);
  assign Full        = (r_count == C_FULL);
  assign Overrun     = r_overrun;

endmodule

// File: tb/tb_receiver_control.sv
// Scoreboard bench for receiver_control: stimulus pushes expected RAM writes and
// read returns into queues; a negedge monitor pops and compares them.
module tb_receiver_control;

  logic        clk, Reset, Received, read;
  logic [15:0] rdrDataOut, rdData, memDataIn, memDataOut;
  logic        rdValid, WriteEnable, Empty, Full, Overrun;
  logic [3:0]  Address;
  logic [4:0]  Count;

  receiver_control #(.WIDTH(16), .AW(4)) dut (
    .clk(clk), .Reset(Reset), .rdrDataOut(rdrDataOut), .Received(Received),
    .read(read), .rdData(rdData), .rdValid(rdValid), .memDataIn(memDataIn),
    .memDataOut(memDataOut), .Address(Address), .WriteEnable(WriteEnable),
    .Count(Count), .Empty(Empty), .Full(Full), .Overrun(Overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External synchronous RAM, one-cycle read latency.
  logic [15:0] ram [16];
  always @(posedge clk) begin
    if (WriteEnable) ram[Address] <= memDataIn;
    memDataOut <= ram[Address];
  end

  typedef struct { logic [3:0] a; logic [15:0] d; } wr_t;
  wr_t         wq[$];
  logic [15:0] rq[$];

  int errors = 0;
  int checks = 0;
  int rd_seen = 0;

  logic [15:0] m_mem [16];
  logic [3:0]  m_wr, m_rd;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every DUT output event must match the head of its queue.
  initial begin
    wr_t e;
    logic [15:0] d;
    forever begin
      @(negedge clk);
      if (!Reset) begin
        if (WriteEnable === 1'b1) begin
          if (wq.size() == 0) chk("unexpected_write", {12'h0, Address, memDataIn}, 32'h0);
          else begin
            e = wq.pop_front();
            chk("write_addr", {28'h0, Address}, {28'h0, e.a});
            chk("write_data", {16'h0, memDataIn}, {16'h0, e.d});
          end
        end
        if (rdValid === 1'b1) begin
          rd_seen++;
          if (rq.size() == 0) chk("unexpected_rdvalid", {16'h0, rdData}, 32'h0);
          else begin
            d = rq.pop_front();
            chk("read_data", {16'h0, rdData}, {16'h0, d});
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    Reset = 1'b1; Received = 1'b0; read = 1'b0; rdrDataOut = '0;
    wq.delete(); rq.delete();
    m_wr = '0; m_rd = '0; m_cnt = 0;
    idle(2);
    Reset = 1'b0;
  endtask

  // One-cycle pulse of Received and/or read; model assumes the DUT is idle.
  task automatic stim(input logic rx, input logic [15:0] w, input logic rd);
    @(posedge clk); #1;
    Received = rx; rdrDataOut = w; read = rd;
    if (rx && m_cnt < 16) begin
      wq.push_back('{m_wr, w});
      m_mem[m_wr] = w; m_wr = m_wr + 4'd1; m_cnt++;
    end
    if (rd && m_cnt > 0) begin
      rq.push_back(m_mem[m_rd]); m_rd = m_rd + 4'd1; m_cnt--;
    end
    @(posedge clk); #1;
    Received = 1'b0; read = 1'b0;
  endtask

  initial begin
    int seen0;
    Reset = 1'b1; Received = 1'b0; read = 1'b0; rdrDataOut = '0;
    do_reset();
    chk("rst_count", {27'h0, Count}, 32'd0);
    chk("rst_empty", {31'h0, Empty}, 32'd1);
    chk("rst_full", {31'h0, Full}, 32'd0);
    chk("rst_overrun", {31'h0, Overrun}, 32'd0);
    chk("rst_we", {31'h0, WriteEnable}, 32'd0);
    chk("rst_rdvalid", {31'h0, rdValid}, 32'd0);
    chk("rst_address", {28'h0, Address}, 32'd0);
    chk("rst_memdin", {16'h0, memDataIn}, 32'd0);
    chk("rst_rddata", {16'h0, rdData}, 32'd0);

    // Single write
    stim(1'b1, 16'hA5A5, 1'b0);
    idle(3);
    chk("one_count", {27'h0, Count}, 32'd1);
    chk("one_empty", {31'h0, Empty}, 32'd0);

    // Three writes, three reads, in order
    do_reset();
    stim(1'b1, 16'h0001, 1'b0); idle(3);
    stim(1'b1, 16'h0002, 1'b0); idle(3);
    stim(1'b1, 16'h0003, 1'b0); idle(3);
    chk("three_count", {27'h0, Count}, 32'd3);
    for (int i = 0; i < 3; i++) begin stim(1'b0, '0, 1'b1); idle(4); end
    chk("drain_count", {27'h0, Count}, 32'd0);
    chk("drain_empty", {31'h0, Empty}, 32'd1);

    // Fill to 16, then overrun
    do_reset();
    for (int i = 0; i < 16; i++) begin stim(1'b1, 16'h1000 + 16'(i), 1'b0); idle(3); end
    chk("fill_count", {27'h0, Count}, 32'd16);
    chk("fill_full", {31'h0, Full}, 32'd1);
    chk("fill_overrun0", {31'h0, Overrun}, 32'd0);
    stim(1'b1, 16'hDEAD, 1'b0); idle(3);
    chk("ovr_flag", {31'h0, Overrun}, 32'd1);
    chk("ovr_count", {27'h0, Count}, 32'd16);
    stim(1'b0, '0, 1'b1); idle(4);
    chk("ovr_sticky", {31'h0, Overrun}, 32'd1);
    chk("ovr_count_after_read", {27'h0, Count}, 32'd15);
    chk("ovr_full_after_read", {31'h0, Full}, 32'd0);

    // Read while empty
    do_reset();
    chk("ovr_cleared", {31'h0, Overrun}, 32'd0);
    seen0 = rd_seen;
    stim(1'b0, '0, 1'b1);
    idle(10);
    chk("empty_read_no_valid", rd_seen - seen0, 32'd0);
    chk("empty_read_count", {27'h0, Count}, 32'd0);

    // 20 write/read pairs, pointers wrap
    do_reset();
    for (int i = 0; i < 20; i++) begin
      stim(1'b1, 16'hB000 + 16'(i * 7), 1'b0); idle(3);
      stim(1'b0, '0, 1'b1); idle(4);
    end
    chk("wrap_count", {27'h0, Count}, 32'd0);

    // Simultaneous Received and read with one word stored
    do_reset();
    stim(1'b1, 16'h1111, 1'b0); idle(3);
    stim(1'b1, 16'h2222, 1'b1);
    idle(3);
    chk("simul_write_first_count", {27'h0, Count}, 32'd2);
    chk("simul_no_early_valid", {31'h0, rdValid}, 32'd0);
    idle(4);
    chk("simul_final_count", {27'h0, Count}, 32'd1);

    idle(4);
    chk("pending_writes", wq.size(), 32'd0);
    chk("pending_reads", rq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/receiver_control.md
RECEIVER_CONTROL -- requirements
Module: receiver_control

Interface
REQ-001 The parameter WIDTH SHALL default to 16 and set the word width.
REQ-002 The parameter AW SHALL default to 4 and set the buffer address width (depth 2^AW = 16).
REQ-003 The port clk SHALL be an input, 1 bit wide, and serve as the single clock, rising edge.
REQ-004 The port Reset SHALL be an input, 1 bit wide, acting as a synchronous, active-high reset.
REQ-005 The port rdrDataOut SHALL be an input, WIDTH bits wide, carrying the word from the deserializer.
REQ-006 The port Received SHALL be an input, 1 bit wide, asserted for one cycle when rdrDataOut holds a valid word.
REQ-007 The port read SHALL be an input, 1 bit wide, asserted for one cycle to request the oldest stored word.
REQ-008 The port rdData SHALL be an output, WIDTH bits wide, carrying the word returned for a read.
REQ-009 The port rdValid SHALL be an output, 1 bit wide, pulsing for one cycle when rdData is valid.
REQ-010 The port memDataIn SHALL be an output, WIDTH bits wide, carrying the write data to the external RAM.
REQ-011 The port memDataOut SHALL be an input, WIDTH bits wide, carrying RAM read data with one-cycle synchronous latency.
REQ-012 The port Address SHALL be an output, AW bits wide, carrying the RAM address.
REQ-013 The port WriteEnable SHALL be an output, 1 bit wide, acting as the RAM write strobe.
REQ-014 The port Count SHALL be an output, AW+1 bits wide, giving the number of stored words (0..16).
REQ-015 The port Empty SHALL be an output, 1 bit wide, equal to Count==0.
REQ-016 The port Full SHALL be an output, 1 bit wide, equal to Count==16.
REQ-017 The port Overrun SHALL be an output, 1 bit wide, acting as a sticky flag for a dropped received word.

Function
REQ-018 The block SHALL operate as a circular buffer with a write pointer wr_ptr and a read pointer rd_ptr, each AW bits wide and wrapping 15->0, plus a count Count.
REQ-019 The block SHALL hold one received word in a holding register (rx_pend flag + word) and one read request in a flag (rd_pend).
REQ-020 The block SHALL accept a word on Received when rx_pend==0 and Count+wr_busy<16 (wr_busy = state in WRITE/AFTER_WRITE), capturing it on that edge; otherwise it SHALL drop the word and set Overrun.
REQ-021 The block SHALL set rd_pend on read and ignore any further read while rd_pend==1 or while in READ/AFTER_READ.
REQ-022 The FSM SHALL have the states IDLE, WRITE, AFTER_WRITE, READ and AFTER_READ; all outputs SHALL be registered.
REQ-023 In IDLE, if rx_pend==1, the FSM SHALL go to WRITE with Address=wr_ptr, memDataIn=held word, WriteEnable=1, and clear rx_pend; writes take priority over reads.
REQ-024 In IDLE, if rx_pend==0, rd_pend==1 and Count>0, the FSM SHALL go to READ with Address=rd_ptr and clear rd_pend.
REQ-025 In IDLE, if rx_pend==0, rd_pend==1 and Count==0, the FSM SHALL clear rd_pend, produce no rdValid, and remain in IDLE.
REQ-026 The FSM SHALL move WRITE->AFTER_WRITE, setting WriteEnable=0; WriteEnable SHALL be high for exactly one cycle per write.
REQ-027 The FSM SHALL move AFTER_WRITE->IDLE, incrementing wr_ptr (with wrap) and incrementing Count.
REQ-028 The FSM SHALL move READ->AFTER_READ with Address held.
REQ-029 The FSM SHALL move AFTER_READ->IDLE, loading rdData<=memDataOut, setting rdValid=1 for one cycle, incrementing rd_ptr (with wrap) and decrementing Count.
REQ-030 Count SHALL never exceed 16 nor underflow below 0, and Empty/Full SHALL follow Count on the same cycle.
REQ-031 Write latency SHALL be as follows: for Received at edge n with the FSM in IDLE, WriteEnable=1 during cycle n+1..n+2 (state WRITE) and Count updates at edge n+3.
REQ-032 Read latency SHALL be as follows: for read at edge m with the FSM in IDLE and rx_pend==0, rdValid=1 in the cycle after edge m+3.
REQ-033 Simultaneous Received and read SHALL both be latched, and the write SHALL be serviced first.
REQ-034 Overrun SHALL clear only on Reset.

Reset
REQ-035 On Reset (sampled at a rising edge), the block SHALL force state=IDLE, wr_ptr=rd_ptr=0, Count=0, rx_pend=rd_pend=0, Overrun=0, rdValid=0, WriteEnable=0, Address=0, memDataIn=0 and rdData=0, and Empty=1, Full=0.
REQ-036 Reset mid-write or mid-read SHALL abort the operation, with no Count change and no rdValid.

Verification
REQ-037 The bench SHALL cover: Reset, then Received with 16'hA5A5 -> one WriteEnable pulse at Address 0 with memDataIn=16'hA5A5; then Count=1 and Empty=0.
REQ-038 The bench SHALL cover: after writing 16'h0001, 16'h0002 and 16'h0003, three read pulses -> rdValid pulses with rdData 1, 2, 3 in order, and finally Count=0 and Empty=1.
REQ-039 The bench SHALL cover: writing 16 words -> Full=1; a 17th Received -> no WriteEnable and Overrun=1, and Overrun stays 1 after a subsequent read.
REQ-040 The bench SHALL cover: read while Empty -> no rdValid within 10 cycles and Count stays 0.
REQ-041 The bench SHALL cover: 20 interleaved write/read pairs -> Address wraps 15->0 and the data stays in order.
REQ-042 The bench SHALL cover: Received and read in the same cycle with Count=1 -> the write completes first (Count=2), then rdValid returns the oldest word.
